// File: rtl/sale_terminal_pkg.sv
// Shared state encoding and key decoding for the sale-terminal controller.
package sale_terminal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_BARCODE     = 3'd1,
        ST_INTERACTIVE = 3'd2,
        ST_QUANTITY    = 3'd3,
        ST_BASKET_EDIT = 3'd4,
        ST_END         = 3'd5
    } state_e;

    // Lowest set bit wins; returns 0 when no key is set (callers gate on |keys).
    function automatic logic [4:0] key_index(input logic [31:0] keys);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (keys[i-1]) idx = 5'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sale_terminal_ctrl_basket_store.sv
// Basket storage: insertion-ordered (PID, qty) entries with merge, compacting delete and clear.
module basket_store
    import sale_terminal_pkg::*;
#(
    parameter int unsigned PID_W = 4,
    parameter int unsigned QTY_W = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       add_i,
    input  logic [PID_W-1:0]           add_pid_i,
    input  logic [QTY_W-1:0]           add_qty_i,
    input  logic                       del_i,
    input  logic [$clog2(DEPTH)-1:0]   del_idx_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       hit_o,
    output logic [PID_W-1:0]           rd_pid_o,
    output logic [QTY_W-1:0]           rd_qty_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PID_W-1:0] pid_q [DEPTH];
    logic [PID_W-1:0] pid_d [DEPTH];
    logic [QTY_W-1:0] qty_q [DEPTH];
    logic [QTY_W-1:0] qty_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] hit_idx;
    logic [QTY_W:0]   sum;

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        hit_o   = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit_o && (CNT_W'(i) < count_q) && (pid_q[i] == add_pid_i)) begin
                hit_o   = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sum = {1'b0, qty_q[hit_idx]} + {1'b0, add_qty_i};

    always_comb begin
        pid_d   = pid_q;
        qty_d   = qty_q;
        count_d = count_q;
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pid_d[i] = '0;
                qty_d[i] = '0;
            end
            count_d = '0;
        end else if (add_i) begin
            if (hit_o) begin
                qty_d[hit_idx] = sum[QTY_W] ? '1 : sum[QTY_W-1:0];
            end else if (!full_o) begin
                pid_d[IDX_W'(count_q)] = add_pid_i;
                qty_d[IDX_W'(count_q)] = add_qty_i;
                count_d                = count_q + CNT_W'(1);
            end
        end else if (del_i) begin
            // Compaction: every slot at or above the deleted index takes its upper neighbour.
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                if (IDX_W'(i) >= del_idx_i) begin
                    pid_d[i] = pid_q[i+1];
                    qty_d[i] = qty_q[i+1];
                end
            end
            pid_d[DEPTH-1] = '0;
            qty_d[DEPTH-1] = '0;
            count_d        = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pid_q[i] <= '0;
                qty_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            pid_q   <= pid_d;
            qty_q   <= qty_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rd_pid_o = '0;
        rd_qty_o = '0;
        if (CNT_W'(rd_idx_i) < count_q) begin
            rd_pid_o = pid_q[rd_idx_i];
            rd_qty_o = qty_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/sale_terminal_ctrl.sv
// Sale-terminal controller: mode FSM, barcode digit entry, product/basket cursors and basket control.
module sale_terminal_ctrl
    import sale_terminal_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned BARCODE_DIGITS = 4,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned PID_W          = 4,
    parameter int unsigned NUM_PRODUCTS   = 12,
    parameter int unsigned QTY_W          = 3,
    parameter int unsigned BASKET_DEPTH   = 8
) (
    input  logic                                  CLOCK_50,
    input  logic                                  RESET,
    input  logic                                  cmd_select,
    input  logic [NUM_KEYS-1:0]                   key_pulse,
    input  logic                                  sw_interactive,
    input  logic                                  sw_basket_edit,
    input  logic                                  lookup_valid,
    input  logic [PID_W-1:0]                      lookup_pid,
    output logic [BARCODE_DIGITS*DIGIT_W-1:0]     barcode_flat,
    output logic [$clog2(BARCODE_DIGITS+1)-1:0]   digit_count,
    output logic [2:0]                            state,
    output logic [$clog2(NUM_PRODUCTS)-1:0]       highlight_idx,
    output logic [$clog2(BASKET_DEPTH)-1:0]       basket_cursor,
    output logic [$clog2(BASKET_DEPTH+1)-1:0]     basket_count,
    input  logic [$clog2(BASKET_DEPTH)-1:0]       rd_idx,
    output logic [PID_W-1:0]                      rd_pid,
    output logic [QTY_W-1:0]                      rd_qty,
    output logic                                  err_invalid,
    output logic                                  err_full,
    output logic                                  shopping_done
);
    localparam int unsigned BC_W   = BARCODE_DIGITS * DIGIT_W;
    localparam int unsigned DCNT_W = $clog2(BARCODE_DIGITS + 1);
    localparam int unsigned HL_W   = $clog2(NUM_PRODUCTS);
    localparam int unsigned CUR_W  = $clog2(BASKET_DEPTH);
    localparam int unsigned CNT_W  = $clog2(BASKET_DEPTH + 1);

    state_e              state_q, state_d;
    logic [BC_W-1:0]     dig_q, dig_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [HL_W-1:0]     hl_q, hl_d;
    logic [CUR_W-1:0]    cur_q, cur_d;
    logic [PID_W-1:0]    pend_q, pend_d;
    logic                einv_q, einv_d;
    logic                efull_q, efull_d;
    logic                done_q, done_d;

    logic                key_any;
    logic [4:0]          key_k;
    logic [DIGIT_W-1:0]  digit;
    logic [QTY_W-1:0]    add_qty;
    logic                add_en, del_en, clr_en;
    logic                bsk_full, bsk_hit;
    logic [CNT_W-1:0]    bcnt;

    assign key_any = |key_pulse;
    assign key_k   = key_index(32'(key_pulse));
    assign digit   = DIGIT_W'(key_k + 5'd1);
    assign add_qty = QTY_W'(key_k + 5'd1);

    basket_store #(
        .PID_W (PID_W),
        .QTY_W (QTY_W),
        .DEPTH (BASKET_DEPTH)
    ) u_basket (
        .clk_i     (CLOCK_50),
        .rst_i     (RESET),
        .clr_i     (clr_en),
        .add_i     (add_en),
        .add_pid_i (pend_q),
        .add_qty_i (add_qty),
        .del_i     (del_en),
        .del_idx_i (cur_q),
        .rd_idx_i  (rd_idx),
        .count_o   (bcnt),
        .full_o    (bsk_full),
        .hit_o     (bsk_hit),
        .rd_pid_o  (rd_pid),
        .rd_qty_o  (rd_qty)
    );

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        dcnt_d  = dcnt_q;
        hl_d    = hl_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        einv_d  = 1'b0;
        efull_d = 1'b0;
        done_d  = 1'b0;
        add_en  = 1'b0;
        del_en  = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_select)          state_d = ST_END;
                else if (sw_basket_edit) state_d = ST_BASKET_EDIT;
                else if (sw_interactive) state_d = ST_INTERACTIVE;
                else                     state_d = ST_BARCODE;
            end
            ST_BARCODE: begin
                // Select is judged against the count before any same-cycle key is shifted in.
                if (sw_interactive || sw_basket_edit) begin
                    dig_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (cmd_select && (dcnt_q == DCNT_W'(BARCODE_DIGITS))) begin
                    dig_d  = '0;
                    dcnt_d = '0;
                    if (lookup_valid) begin
                        pend_d  = lookup_pid;
                        state_d = ST_QUANTITY;
                    end else begin
                        einv_d = 1'b1;
                    end
                end else if (key_any && (dcnt_q < DCNT_W'(BARCODE_DIGITS))) begin
                    dig_d  = {dig_q[BC_W-DIGIT_W-1:0], digit};
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            ST_INTERACTIVE: begin
                if (!sw_interactive) begin
                    state_d = ST_IDLE;
                end else if (cmd_select) begin
                    pend_d  = PID_W'(hl_q);
                    state_d = ST_QUANTITY;
                end else if (key_any && key_k == 5'd0) begin
                    hl_d = (hl_q == '0) ? HL_W'(NUM_PRODUCTS - 1) : hl_q - HL_W'(1);
                end else if (key_any && key_k == 5'd1) begin
                    hl_d = (hl_q == HL_W'(NUM_PRODUCTS - 1)) ? '0 : hl_q + HL_W'(1);
                end
            end
            ST_QUANTITY: begin
                if (key_any) begin
                    add_en  = 1'b1;
                    efull_d = !bsk_hit && bsk_full;
                    state_d = ST_IDLE;
                end else if (cmd_select) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BASKET_EDIT: begin
                if (!sw_basket_edit) begin
                    state_d = ST_IDLE;
                end else if (cmd_select) begin
                    if (bcnt != '0) begin
                        del_en = 1'b1;
                        // Cursor on the last entry falls back onto the new last entry.
                        if ((CNT_W'(cur_q) + CNT_W'(1)) >= bcnt)
                            cur_d = (bcnt > CNT_W'(1)) ? CUR_W'(bcnt - CNT_W'(2)) : '0;
                    end
                end else if (key_any && (bcnt != '0)) begin
                    if (key_k == 5'd0)
                        cur_d = (cur_q == '0) ? CUR_W'(bcnt - CNT_W'(1)) : cur_q - CUR_W'(1);
                    else if (key_k == 5'd1)
                        cur_d = (CNT_W'(cur_q) == bcnt - CNT_W'(1)) ? '0 : cur_q + CUR_W'(1);
                end
            end
            ST_END: begin
                clr_en  = 1'b1;
                dig_d   = '0;
                dcnt_d  = '0;
                hl_d    = '0;
                cur_d   = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            dig_q   <= '0;
            dcnt_q  <= '0;
            hl_q    <= '0;
            cur_q   <= '0;
            pend_q  <= '0;
            einv_q  <= 1'b0;
            efull_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            dcnt_q  <= dcnt_d;
            hl_q    <= hl_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            einv_q  <= einv_d;
            efull_q <= efull_d;
            done_q  <= done_d;
        end
    end

    assign barcode_flat  = dig_q;
    assign digit_count   = dcnt_q;
    assign state         = state_q;
    assign highlight_idx = hl_q;
    assign basket_cursor = cur_q;
    assign basket_count  = bcnt;
    assign err_invalid   = einv_q;
    assign err_full      = efull_q;
    assign shopping_done = done_q;

endmodule

// File: tb/tb_sale_terminal_ctrl.sv
// Scoreboard bench: driver steps a queue-based reference model, monitor compares every cycle.
module tb_sale_terminal_ctrl;

    logic        clk = 1'b0;
    logic        rst, sel, swi, swb, lv;
    logic [3:0]  keys, lpid;
    logic [2:0]  rd_idx;
    logic [15:0] barcode_flat;
    logic [2:0]  digit_count, state, basket_cursor;
    logic [3:0]  highlight_idx, basket_count, rd_pid;
    logic [2:0]  rd_qty;
    logic        err_invalid, err_full, shopping_done;

    always #5 clk = ~clk;

    sale_terminal_ctrl #(
        .NUM_KEYS(4), .BARCODE_DIGITS(4), .DIGIT_W(4), .PID_W(4),
        .NUM_PRODUCTS(12), .QTY_W(3), .BASKET_DEPTH(8)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .cmd_select(sel), .key_pulse(keys),
        .sw_interactive(swi), .sw_basket_edit(swb), .lookup_valid(lv), .lookup_pid(lpid),
        .barcode_flat(barcode_flat), .digit_count(digit_count), .state(state),
        .highlight_idx(highlight_idx), .basket_cursor(basket_cursor), .basket_count(basket_count),
        .rd_idx(rd_idx), .rd_pid(rd_pid), .rd_qty(rd_qty), .err_invalid(err_invalid),
        .err_full(err_full), .shopping_done(shopping_done)
    );

    localparam int M_IDLE = 0, M_BC = 1, M_INT = 2, M_QTY = 3, M_BE = 4, M_END = 5;

    typedef struct { int st; int bc; int dc; int hl; int cur; int cnt; int rp; int rq; int ei; int ef; int dn; } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    // Reference model: digits newest-first, basket as parallel queues in insertion order.
    int mst, mhl, mcur, mpend, m_ei, m_ef, m_dn;
    int mdig[$];
    int bp[$];
    int bq[$];

    // Stimulus levels held between cycles.
    logic       swi_lv = 1'b0, swb_lv = 1'b0, lv_v = 1'b0;
    logic [3:0] lpid_v = '0;
    logic [2:0] rdi = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mst = M_IDLE; mhl = 0; mcur = 0; mpend = 0;
        m_ei = 0; m_ef = 0; m_dn = 0;
        mdig.delete(); bp.delete(); bq.delete();
    endtask

    task automatic basket_add(input int pid, input int q);
        int found;
        found = -1;
        foreach (bp[j]) if (found < 0 && bp[j] == pid) found = j;
        if (found >= 0)          bq[found] = (bq[found] + q > 7) ? 7 : bq[found] + q;
        else if (bp.size() < 8)  begin bp.push_back(pid); bq.push_back(q); end
        else                     m_ef = 1;
    endtask

    task automatic model_step(input logic s, input logic [3:0] k4, input logic wi, input logic wb,
                              input logic v, input logic [3:0] p);
        int k, n;
        k = -1;
        for (int i = 3; i >= 0; i--) if (k4[i]) k = i;
        m_ei = 0; m_ef = 0; m_dn = 0;
        n = bp.size();
        case (mst)
            M_IDLE: mst = s ? M_END : wb ? M_BE : wi ? M_INT : M_BC;
            M_BC: begin
                if (wi || wb) begin mdig.delete(); mst = M_IDLE; end
                else if (s && mdig.size() == 4) begin
                    mdig.delete();
                    if (v) begin mpend = int'(p); mst = M_QTY; end
                    else m_ei = 1;
                end else if (k >= 0 && mdig.size() < 4) mdig.push_front(k + 1);
            end
            M_INT: begin
                if (!wi) mst = M_IDLE;
                else if (s) begin mpend = mhl; mst = M_QTY; end
                else if (k == 0) mhl = (mhl + 11) % 12;
                else if (k == 1) mhl = (mhl + 1) % 12;
            end
            M_QTY: begin
                if (k >= 0) begin basket_add(mpend, k + 1); mst = M_IDLE; end
                else if (s) mst = M_IDLE;
            end
            M_BE: begin
                if (!wb) mst = M_IDLE;
                else if (s) begin
                    if (n > 0) begin
                        bp.delete(mcur); bq.delete(mcur);
                        n = n - 1;
                        if (n == 0) mcur = 0;
                        else if (mcur >= n) mcur = n - 1;
                    end
                end else if (k == 0 && n > 0) mcur = (mcur + n - 1) % n;
                else if (k == 1 && n > 0) mcur = (mcur + 1) % n;
            end
            M_END: begin
                bp.delete(); bq.delete(); mdig.delete();
                mhl = 0; mcur = 0; m_dn = 1; mst = M_IDLE;
            end
            default: mst = M_IDLE;
        endcase
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st = mst; e.dc = mdig.size(); e.hl = mhl; e.cur = mcur; e.cnt = bp.size();
        e.bc = 0;
        foreach (mdig[i]) e.bc += mdig[i] << (4 * i);
        e.rp = (int'(rdi) < bp.size()) ? bp[rdi] : 0;
        e.rq = (int'(rdi) < bp.size()) ? bq[rdi] : 0;
        e.ei = m_ei; e.ef = m_ef; e.dn = m_dn;
        return e;
    endfunction

    task automatic apply(input logic r, input logic s, input logic [3:0] k);
        @(negedge clk);
        rst = r; sel = s; keys = k; swi = swi_lv; swb = swb_lv;
        lv = lv_v; lpid = lpid_v; rd_idx = rdi;
        if (r) model_reset();
        else   model_step(s, k, swi_lv, swb_lv, lv_v, lpid_v);
        sb.push_back(snap());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // From IDLE with both switches low: scan digits 1-2-3-4, look up pid, add quantity via key qk.
    task automatic add_via_barcode(input int pid, input logic [3:0] qk);
        swi_lv = 1'b0; swb_lv = 1'b0;
        apply(0, 0, 4'b0000);
        for (int i = 0; i < 4; i++) apply(0, 0, 4'(1 << i));
        lv_v = 1'b1; lpid_v = 4'(pid);
        apply(0, 1, 4'b0000);
        apply(0, 0, qk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state", state, e.st);
                chk("barcode_flat", barcode_flat, e.bc);
                chk("digit_count", digit_count, e.dc);
                chk("highlight_idx", highlight_idx, e.hl);
                chk("basket_cursor", basket_cursor, e.cur);
                chk("basket_count", basket_count, e.cnt);
                chk("rd_pid", rd_pid, e.rp);
                chk("rd_qty", rd_qty, e.rq);
                chk("err_invalid", err_invalid, e.ei);
                chk("err_full", err_full, e.ef);
                chk("shopping_done", shopping_done, e.dn);
            end
        end
    end

    initial begin : driver
        rst = 1'b1; sel = 1'b0; keys = '0; swi = 1'b0; swb = 1'b0; lv = 1'b0; lpid = '0; rd_idx = '0;

        // Barcode 1-2-3-4 -> pid 5, quantity 2.
        apply(1, 0, 4'b0000);
        settle();
        chk("rst_state", state, 0);
        chk("rst_count", basket_count, 0);
        apply(0, 0, 4'b0000);
        apply(0, 0, 4'b0001); apply(0, 0, 4'b0010); apply(0, 0, 4'b0100); apply(0, 0, 4'b1000);
        settle();
        chk("bc_1234", barcode_flat, 32'h1234);
        lv_v = 1'b1; lpid_v = 4'd5;
        apply(0, 1, 4'b0000);
        apply(0, 0, 4'b0010);
        settle();
        chk("add1_count", basket_count, 1);
        chk("add1_pid", rd_pid, 5);
        chk("add1_qty", rd_qty, 2);
        chk("add1_state", state, 0);

        // Invalid barcode; fifth key ignored.
        apply(0, 0, 4'b0000);
        apply(0, 0, 4'b0001); apply(0, 0, 4'b0010); apply(0, 0, 4'b0100); apply(0, 0, 4'b1000);
        apply(0, 0, 4'b0001);
        settle();
        chk("bc_5th_key", barcode_flat, 32'h1234);
        lv_v = 1'b0;
        apply(0, 1, 4'b0000);
        settle();
        chk("inv_pulse", err_invalid, 1);
        chk("inv_dcnt", digit_count, 0);
        chk("inv_state", state, 1);
        apply(0, 0, 4'b0000);
        settle();
        chk("inv_pulse_end", err_invalid, 0);

        // Interactive wrap and saturating merge.
        swi_lv = 1'b1;
        apply(0, 0, 4'b0000);
        apply(0, 0, 4'b0000);
        apply(0, 0, 4'b0001);
        settle();
        chk("hl_wrap", highlight_idx, 11);
        apply(0, 1, 4'b0000);
        rdi = 3'd1;
        apply(0, 0, 4'b1000);
        settle();
        chk("int_pid", rd_pid, 11);
        chk("int_qty", rd_qty, 4);
        apply(0, 0, 4'b0000);
        apply(0, 1, 4'b0000);
        apply(0, 0, 4'b1000);
        settle();
        chk("sat_qty", rd_qty, 7);

        // Fill to eight, ninth distinct pid is dropped.
        add_via_barcode(0, 4'b0001); add_via_barcode(1, 4'b0001); add_via_barcode(2, 4'b0001);
        add_via_barcode(3, 4'b0001); add_via_barcode(4, 4'b0001); add_via_barcode(6, 4'b0001);
        add_via_barcode(7, 4'b0001);
        settle();
        chk("full_pulse", err_full, 1);
        chk("full_count", basket_count, 8);

        // Basket edit deletions.
        rdi = 3'd0;
        apply(1, 0, 4'b0000);
        add_via_barcode(1, 4'b0100); add_via_barcode(2, 4'b0100); add_via_barcode(3, 4'b0100);
        swb_lv = 1'b1; rdi = 3'd1;
        apply(0, 0, 4'b0000);
        apply(0, 0, 4'b0010);
        apply(0, 0, 4'b0010);
        settle();
        chk("be_cursor2", basket_cursor, 2);
        apply(0, 1, 4'b0000);
        settle();
        chk("del_count", basket_count, 2);
        chk("del_cursor", basket_cursor, 1);
        chk("del_keep_pid", rd_pid, 2);
        chk("del_keep_qty", rd_qty, 3);
        apply(0, 1, 4'b0000);
        apply(0, 1, 4'b0000);
        settle();
        chk("del_empty_cnt", basket_count, 0);
        chk("del_empty_cur", basket_cursor, 0);

        // End of shopping.
        swb_lv = 1'b0;
        apply(0, 0, 4'b0000);
        add_via_barcode(9, 4'b0001);
        apply(0, 1, 4'b0000);
        settle();
        chk("end_state", state, 5);
        apply(0, 0, 4'b0000);
        settle();
        chk("done_pulse", shopping_done, 1);
        chk("done_count", basket_count, 0);

        // Reset while waiting for a quantity.
        apply(0, 0, 4'b0000);
        for (int i = 0; i < 4; i++) apply(0, 0, 4'b0010);
        lv_v = 1'b1;
        apply(0, 1, 4'b0000);
        settle();
        chk("qty_state", state, 3);
        apply(1, 0, 4'b0000);
        #1;
        chk("async_rst", state, 0);
        apply(0, 0, 4'b1000);
        settle();
        chk("lost_add", basket_count, 0);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            logic r, s;
            logic [3:0] k;
            r = ($urandom % 150) == 0;
            if ($urandom % 20 == 0) swi_lv = ~swi_lv;
            if ($urandom % 25 == 0) swb_lv = ~swb_lv;
            lv_v = 1'($urandom); lpid_v = 4'($urandom); rdi = 3'($urandom);
            s = ($urandom % 100) < 12;
            k = (($urandom % 100) < 40) ? 4'($urandom) : 4'b0000;
            apply(r, s, k);
        end

        settle();
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
